ncl_digit_reader: RTL and testbench
===================================

NCL_DIGIT_READER -- requirements
Module: ncl_digit_reader

Interface
REQ-001 Parameter WIDTH, default 32: number of dual-rail digits read per wavefront.
REQ-002 Parameter SYNC_STAGES, default 2: flop depth of the input synchronizer on every rail.
REQ-003 Parameter CHECK_SEQ, default 1: 1 enables the count-sequence check.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 init_n  input  1: reset, asynchronous assertion, active-low.
REQ-006 sum  input  2*WIDTH: dual-rail digits; sum[2i] is rail0 of digit i, sum[2i+1] is rail1; 00 = NULL, 01 = DATA0, 10 = DATA1, 11 = illegal.
REQ-007 sumcomp  output  1: completion acknowledge, fanned to every digit stage; high = DATA accepted, send NULL; low = NULL accepted, send DATA.
REQ-008 data_out  output  WIDTH: captured binary word; bit i = rail1 of digit i.
REQ-009 valid  output  1: data_out holds an unconsumed word.
REQ-010 ready  input  1: consumer accepts data_out when valid && ready.
REQ-011 code_err  output  1: sticky; an illegal 11 digit was seen.
REQ-012 seq_err  output  1: sticky; a captured word was not the previous word + 1 (mod 2^WIDTH).

Function
REQ-013 Each rail SHALL pass through SYNC_STAGES flops before any use; "sampled" below means the synchronizer output.
REQ-014 complete = every digit sampled 01 or 10; null = every rail sampled 0.
REQ-015 A condition SHALL count as stable only when the sampled rail vector is identical on two consecutive clocks and meets the condition both times.
REQ-016 The FSM SHALL have states WAIT_DATA (sumcomp=0) and WAIT_NULL (sumcomp=1).
REQ-017 WAIT_DATA -> WAIT_NULL SHALL occur when complete is stable and the output register is free (valid=0, or valid && ready in the same cycle).
REQ-018 On that transition, data_out SHALL load the rail1 bits and valid SHALL be 1 on the next clock.
REQ-019 sumcomp SHALL be registered and rise on the same edge as valid.
REQ-020 If complete is stable but the output register is occupied, the FSM SHALL remain in WAIT_DATA with sumcomp=0, backpressuring the ring.
REQ-021 WAIT_NULL -> WAIT_DATA SHALL occur when null is stable; sumcomp falls on the next clock.
REQ-022 Latency: a DATA wavefront stable at the pins before edge k SHALL produce valid=1 and sumcomp=1 after edge k+SYNC_STAGES+1.
REQ-023 valid SHALL clear on valid && ready unless a new capture occurs in the same cycle, in which case valid stays 1 with the new word.
REQ-024 Any sampled 11 digit SHALL set code_err; that digit counts as incomplete, so the FSM waits.
REQ-025 If CHECK_SEQ=1, every capture after the first SHALL compare against the previous capture + 1 (mod 2^WIDTH); on mismatch it SHALL set seq_err.
REQ-026 The first capture after reset SHALL only seed the comparison; wrap from all-ones to 0 is legal.
REQ-027 Partial wavefronts (mixed NULL/DATA digits) SHALL cause no state change in either state.

Reset
REQ-028 Assertion of init_n=0 SHALL immediately force: state WAIT_DATA, sumcomp=0, valid=0, data_out=0, code_err=0, seq_err=0, synchronizer flops=0, sequence seed cleared.
REQ-029 Reset mid-handshake SHALL abandon any pending word; after deassertion the first complete wavefront seeds the sequence check.

Structure
REQ-030 A shared package SHALL hold the state enum (WAIT_DATA, WAIT_NULL) and the rail encodings (NULL, DATA0, DATA1, ILLEGAL).
REQ-031 One sub-module, ncl_rail_sync (SYNC_STAGES-deep, parameter width), SHALL implement the synchronizer and be instantiated once for the 2*WIDTH rails.

Verification
REQ-032 Reset, then drive DATA 5 (digits 0,2 = 10, others 01) with ready=1 -> data_out=5, valid=1 and sumcomp=1 at edge SYNC_STAGES+2; drive NULL -> sumcomp=0 after the same latency.
REQ-033 Drive sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0 with NULL between each -> three captures, seq_err=0.
REQ-034 ready=0 after the first capture, then present the next DATA -> sumcomp stays 0 and data_out unchanged until ready=1, then capture occurs within 1 clock.
REQ-035 Digit 7 driven 11 in an otherwise complete wavefront -> code_err=1, no capture, sumcomp=0; fix to 01 -> capture proceeds, code_err remains 1.
REQ-036 Captures 3 then 5 -> seq_err=1; assert init_n=0 mid WAIT_NULL -> all outputs 0 immediately, next capture of 9 raises no seq_err.
REQ-037 Skew digits arriving over 3 clocks (partial wavefront) -> no capture until all digits complete and stable for two consecutive samples.

Source files
------------

// File: rtl/ncl_digit_reader_pkg.sv
// Shared types for the NCL digit reader.
//   state_e : handshake FSM states (WAIT_DATA drives sumcomp low, WAIT_NULL high)
//   rail_e  : dual-rail digit encodings as {rail1, rail0}
package ncl_digit_reader_pkg;

    typedef enum logic {
        WAIT_DATA = 1'b0,
        WAIT_NULL = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        RAIL_NULL    = 2'b00,
        RAIL_DATA0   = 2'b01,
        RAIL_DATA1   = 2'b10,
        RAIL_ILLEGAL = 2'b11
    } rail_e;

endpackage

// File: rtl/ncl_digit_reader_rail_sync.sv
// Multi-flop synchronizer for a bundle of asynchronous rails.
//   clk_i    : sampling clock
//   rst_ni   : asynchronous active-low reset, clears every stage
//   rails_i  : asynchronous rail inputs
//   rails_o  : rails after STAGES flops
module ncl_rail_sync #(
    parameter int unsigned WIDTH  = 2,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] rails_i,
    output logic [WIDTH-1:0] rails_o
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    always_comb begin
        stage_d[0] = rails_i;
        for (int unsigned s = 1; s < STAGES; s++) begin
            stage_d[s] = stage_q[s-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                stage_q[s] <= stage_d[s];
            end
        end
    end

    assign rails_o = stage_q[STAGES-1];

endmodule

// File: rtl/ncl_digit_reader.sv
// Reads dual-rail NCL wavefronts into a binary word with a valid/ready output.
//   clk      : single clock
//   init_n   : asynchronous active-low reset
//   sum      : dual-rail digits, sum[2i] = rail0, sum[2i+1] = rail1 of digit i
//   sumcomp  : completion acknowledge back to the ring (1 = send NULL, 0 = send DATA)
//   data_out : last captured word (rail1 of each digit)
//   valid    : data_out not yet consumed
//   ready    : consumer takes data_out when valid && ready
//   code_err : sticky, an illegal 11 digit was sampled
//   seq_err  : sticky, a capture was not previous capture + 1
module ncl_digit_reader
    import ncl_digit_reader_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CHECK_SEQ   = 1
) (
    input  logic               clk,
    input  logic               init_n,
    input  logic [2*WIDTH-1:0] sum,
    output logic               sumcomp,
    output logic [WIDTH-1:0]   data_out,
    output logic               valid,
    input  logic               ready,
    output logic               code_err,
    output logic               seq_err
);

    logic [2*WIDTH-1:0] sampled;
    logic [2*WIDTH-1:0] prev_q, prev_d;
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic               valid_q, valid_d;
    logic               code_err_q, code_err_d;
    logic               seq_err_q, seq_err_d;
    logic               seeded_q, seeded_d;

    logic               complete_now, illegal_now, null_now;
    logic               sample_same, complete_stable, null_stable;
    logic               reg_free, capture;
    logic [WIDTH-1:0]   rail1;
    rail_e              digit;

    ncl_rail_sync #(
        .WIDTH  (2 * WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_rail_sync (
        .clk_i   (clk),
        .rst_ni  (init_n),
        .rails_i (sum),
        .rails_o (sampled)
    );

    // Per-digit decode of the synchronized rails.
    always_comb begin
        complete_now = 1'b1;
        illegal_now  = 1'b0;
        rail1        = '0;
        digit        = RAIL_NULL;
        for (int i = 0; i < int'(WIDTH); i++) begin
            digit = rail_e'(sampled[2*i +: 2]);
            if (digit != RAIL_DATA0 && digit != RAIL_DATA1) begin
                complete_now = 1'b0;
            end
            if (digit == RAIL_ILLEGAL) begin
                illegal_now = 1'b1;
            end
            rail1[i] = sampled[2*i+1];
        end
    end

    // Identical vector on two consecutive samples filters skewed arrivals.
    assign null_now        = (sampled == '0);
    assign sample_same     = (sampled == prev_q);
    assign complete_stable = sample_same && complete_now;
    assign null_stable     = sample_same && null_now;
    assign reg_free        = !valid_q || ready;

    always_comb begin
        prev_d     = sampled;
        state_d    = state_q;
        data_out_d = data_out_q;
        valid_d    = valid_q;
        code_err_d = code_err_q | illegal_now;
        seq_err_d  = seq_err_q;
        seeded_d   = seeded_q;
        capture    = 1'b0;

        case (state_q)
            WAIT_DATA: begin
                // Holding off here keeps sumcomp low, which stalls the ring.
                if (complete_stable && reg_free) begin
                    capture = 1'b1;
                    state_d = WAIT_NULL;
                end
            end
            WAIT_NULL: begin
                if (null_stable) begin
                    state_d = WAIT_DATA;
                end
            end
            default: state_d = WAIT_DATA;
        endcase

        if (capture) begin
            data_out_d = rail1;
            valid_d    = 1'b1;
            seeded_d   = 1'b1;
            // data_out_q still holds the previous capture at this point.
            if ((CHECK_SEQ != 0) && seeded_q && (rail1 != data_out_q + WIDTH'(1))) begin
                seq_err_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            prev_q     <= '0;
            state_q    <= WAIT_DATA;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            code_err_q <= 1'b0;
            seq_err_q  <= 1'b0;
            seeded_q   <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            state_q    <= state_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            code_err_q <= code_err_d;
            seq_err_q  <= seq_err_d;
            seeded_q   <= seeded_d;
        end
    end

    assign sumcomp  = (state_q == WAIT_NULL);
    assign data_out = data_out_q;
    assign valid    = valid_q;
    assign code_err = code_err_q;
    assign seq_err  = seq_err_q;

endmodule

// File: tb/tb_ncl_digit_reader.sv
module tb_ncl_digit_reader;

    localparam int W    = 32;
    localparam int SYNC = 2;

    logic           clk = 1'b0;
    logic           init_n = 1'b0;
    logic [2*W-1:0] sum = '0;
    logic           ready = 1'b1;
    logic           sumcomp, valid, code_err, seq_err;
    logic [W-1:0]   data_out;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: sequence rule as plain arithmetic on captured words.
    logic         m_seeded  = 1'b0;
    logic [W-1:0] m_prev    = '0;
    logic         m_seq_err = 1'b0;

    ncl_digit_reader #(
        .WIDTH       (W),
        .SYNC_STAGES (SYNC),
        .CHECK_SEQ   (1)
    ) dut (
        .clk      (clk),
        .init_n   (init_n),
        .sum      (sum),
        .sumcomp  (sumcomp),
        .data_out (data_out),
        .valid    (valid),
        .ready    (ready),
        .code_err (code_err),
        .seq_err  (seq_err)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [2*W-1:0] enc(input logic [W-1:0] w);
        logic [2*W-1:0] e;
        for (int i = 0; i < W; i++) begin
            e[2*i+1] = w[i];
            e[2*i]   = ~w[i];
        end
        return e;
    endfunction

    function automatic void model_capture(input logic [W-1:0] w);
        logic [W-1:0] nxt;
        nxt = m_prev + 1'b1;
        if (m_seeded && (w != nxt)) m_seq_err = 1'b1;
        m_seeded = 1'b1;
        m_prev   = w;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        init_n = 1'b0;
        sum    = '0;
        ready  = 1'b1;
        repeat (2) @(negedge clk);
        init_n    = 1'b1;
        m_seeded  = 1'b0;
        m_prev    = '0;
        m_seq_err = 1'b0;
        @(negedge clk);
    endtask

    // Full DATA/NULL handshake; returns outputs seen when sumcomp rose.
    task automatic do_word(input logic [W-1:0] w, input bit skew,
                           output logic [W-1:0] got, output logic got_seq,
                           output bit timeout);
        logic [2*W-1:0] cur;
        int             arrive [W];
        int             n;
        timeout = 0;
        @(negedge clk);
        if (skew) begin
            cur = '0;
            for (int i = 0; i < W; i++) arrive[i] = int'($urandom_range(0, 3));
            for (int step = 0; step < 4; step++) begin
                for (int i = 0; i < W; i++) begin
                    if (arrive[i] <= step) begin
                        cur[2*i+1] = w[i];
                        cur[2*i]   = ~w[i];
                    end
                end
                sum = cur;
                if (step < 3) @(negedge clk);
            end
        end else begin
            sum = enc(w);
        end
        n = 0;
        while (sumcomp !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sumcomp !== 1'b1) timeout = 1;
        got     = data_out;
        got_seq = seq_err;
        sum     = '0;
        n       = 0;
        while (sumcomp !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sumcomp !== 1'b0) timeout = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        init_n = 1'b1;
        @(negedge clk);
        #2 init_n = 1'b0;
        #1;
        n_cmp++;
        if ({sumcomp, valid, code_err, seq_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 0000", {sumcomp, valid, code_err, seq_err});
        end
        n_cmp++;
        if (data_out !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 0", data_out);
        end
        apply_reset();
    endtask

    task automatic test_latency();
        logic [W-1:0] w;
        w = 32'd5;
        @(negedge clk);
        sum = enc(w);
        repeat (SYNC + 1) @(negedge clk);
        n_cmp++;
        if ({sumcomp, valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL latency_early: sumcomp,valid got %b required 00", {sumcomp, valid});
        end
        @(negedge clk);
        n_cmp++;
        if ({sumcomp, valid} !== 2'b11 || data_out !== w) begin
            n_fail++;
            $display("FAIL latency_capture: sumcomp,valid got %b data %h required 11 data %h",
                     {sumcomp, valid}, data_out, w);
        end
        model_capture(w);
        sum = '0;
        repeat (SYNC + 1) @(negedge clk);
        n_cmp++;
        if (sumcomp !== 1'b1) begin
            n_fail++;
            $display("FAIL null_early: sumcomp got %b required 1", sumcomp);
        end
        @(negedge clk);
        n_cmp++;
        if (sumcomp !== 1'b0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL null_release: sumcomp,valid got %b required 00", {sumcomp, valid});
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] words [3];
        logic [W-1:0] got;
        logic         gs;
        bit           to;
        apply_reset();
        words[0] = 32'hFFFF_FFFE;
        words[1] = 32'hFFFF_FFFF;
        words[2] = 32'h0000_0000;
        for (int k = 0; k < 3; k++) begin
            do_word(words[k], 1'b0, got, gs, to);
            model_capture(words[k]);
            n_cmp++;
            if (to || got !== words[k] || gs !== m_seq_err) begin
                n_fail++;
                $display("FAIL wrap_%0d: timeout %0d data %h seq_err %b required data %h seq_err %b",
                         k, to, got, gs, words[k], m_seq_err);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a;
        logic [W-1:0] got;
        logic         gs;
        bit           to;
        apply_reset();
        a     = $urandom;
        ready = 1'b0;
        do_word(a, 1'b0, got, gs, to);
        model_capture(a);
        n_cmp++;
        if (to || got !== a || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first: timeout %0d data %h valid %b required data %h valid 1",
                     to, got, valid, a);
        end
        sum = enc(a + 1'b1);
        repeat (10) @(negedge clk);
        n_cmp++;
        if (sumcomp !== 1'b0 || data_out !== a || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: sumcomp %b data %h valid %b required 0 %h 1",
                     sumcomp, data_out, valid, a);
        end
        ready = 1'b1;
        @(negedge clk);
        model_capture(a + 1'b1);
        n_cmp++;
        if (sumcomp !== 1'b1 || data_out !== a + 1'b1 || valid !== 1'b1 || seq_err !== m_seq_err) begin
            n_fail++;
            $display("FAIL bp_release: sumcomp %b data %h valid %b seq_err %b required 1 %h 1 %b",
                     sumcomp, data_out, valid, seq_err, a + 1'b1, m_seq_err);
        end
        sum = '0;
        repeat (SYNC + 3) @(negedge clk);
    endtask

    task automatic test_code_err();
        logic [W-1:0]   w, fixed;
        logic [2*W-1:0] v;
        int             n;
        w     = m_prev + 1'b1;
        fixed = w;
        fixed[7] = 1'b0;
        v     = enc(w);
        v[15:14] = 2'b11;
        @(negedge clk);
        sum = v;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (code_err !== 1'b1 || sumcomp !== 1'b0 || data_out !== m_prev) begin
            n_fail++;
            $display("FAIL code_err_hold: code_err %b sumcomp %b data %h required 1 0 %h",
                     code_err, sumcomp, data_out, m_prev);
        end
        v[15:14] = 2'b01;
        sum = v;
        n = 0;
        while (sumcomp !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        model_capture(fixed);
        n_cmp++;
        if (sumcomp !== 1'b1 || data_out !== fixed || code_err !== 1'b1 || seq_err !== m_seq_err) begin
            n_fail++;
            $display("FAIL code_err_fix: sumcomp %b data %h code_err %b seq_err %b required 1 %h 1 %b",
                     sumcomp, data_out, code_err, seq_err, fixed, m_seq_err);
        end
        sum = '0;
        repeat (SYNC + 3) @(negedge clk);
    endtask

    task automatic test_seq_reset();
        logic [W-1:0] got;
        logic         gs;
        bit           to;
        int           n;
        apply_reset();
        do_word(32'd3, 1'b0, got, gs, to);
        model_capture(32'd3);
        do_word(32'd5, 1'b0, got, gs, to);
        model_capture(32'd5);
        n_cmp++;
        if (to || got !== 32'd5 || gs !== m_seq_err) begin
            n_fail++;
            $display("FAIL seq_3_5: timeout %0d data %h seq_err %b required 5 seq_err %b",
                     to, got, gs, m_seq_err);
        end
        @(negedge clk);
        sum = enc(32'd6);
        n = 0;
        while (sumcomp !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        #2 init_n = 1'b0;
        #1;
        n_cmp++;
        if ({sumcomp, valid, code_err, seq_err} !== 4'b0000 || data_out !== '0) begin
            n_fail++;
            $display("FAIL midreset: flags %b data %h required 0000 data 0",
                     {sumcomp, valid, code_err, seq_err}, data_out);
        end
        sum = '0;
        @(negedge clk);
        init_n    = 1'b1;
        m_seeded  = 1'b0;
        m_seq_err = 1'b0;
        do_word(32'd9, 1'b0, got, gs, to);
        model_capture(32'd9);
        n_cmp++;
        if (to || got !== 32'd9 || gs !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_seed: timeout %0d data %h seq_err %b required 9 seq_err 0",
                     to, got, gs);
        end
    endtask

    task automatic test_skew();
        logic [W-1:0]   w;
        logic [2*W-1:0] cur;
        int             n;
        w   = m_prev + 1'b1;
        cur = '0;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < W; i++) begin
                if (i % 3 == g) begin
                    cur[2*i+1] = w[i];
                    cur[2*i]   = ~w[i];
                end
            end
            sum = cur;
            if (g < 2) begin
                @(negedge clk);
                n_cmp++;
                if (sumcomp !== 1'b0) begin
                    n_fail++;
                    $display("FAIL skew_partial_%0d: sumcomp got %b required 0", g, sumcomp);
                end
            end
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sumcomp !== 1'b1 && n < 40);
        model_capture(w);
        n_cmp++;
        if (n != SYNC + 2 || data_out !== w || seq_err !== m_seq_err) begin
            n_fail++;
            $display("FAIL skew_capture: cycles %0d data %h seq_err %b required %0d %h %b",
                     n, data_out, seq_err, SYNC + 2, w, m_seq_err);
        end
        sum = '0;
        repeat (SYNC + 3) @(negedge clk);
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        logic [W-1:0] got;
        logic         gs;
        bit           to;
        bit           skew;
        logic         rdy;
        for (int k = 0; k < 16; k++) begin
            w    = ($urandom_range(0, 3) == 0) ? $urandom : m_prev + 1'b1;
            skew = 1'($urandom_range(0, 1));
            rdy  = 1'($urandom_range(0, 1));
            ready = rdy;
            do_word(w, skew, got, gs, to);
            model_capture(w);
            n_cmp++;
            if (to || got !== w || gs !== m_seq_err) begin
                n_fail++;
                $display("FAIL rand_%0d: timeout %0d data %h seq_err %b required data %h seq_err %b",
                         k, to, got, gs, w, m_seq_err);
            end
            n_cmp++;
            if (valid !== ~rdy) begin
                n_fail++;
                $display("FAIL rand_valid_%0d: valid got %b required %b", k, valid, ~rdy);
            end
            ready = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_consume_%0d: valid got %b required 0", k, valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_wrap();
        test_backpressure();
        test_code_err();
        test_seq_reset();
        test_skew();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
